// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a two-entry skid buffer, valid/ready handshake,
// synchronous flush and bubble masking of the control bundle.
module pipe_skid_reg #(
    parameter int                CTRL_W    = 2,
    parameter int                DATA_W    = 69,
    parameter logic [CTRL_W-1:0] CTRL_IDLE = '0,
    parameter bit                NEGEDGE   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl, w_m_ctrl_nxt, w_s_ctrl_nxt;
    logic [DATA_W-1:0] r_m_data, r_s_data, w_m_data_nxt, w_s_data_nxt;
    logic              w_clk;
    logic              w_accept;
    logic              w_pop;

    // Inverting the clock keeps one set of registers for both edge choices.
    assign w_clk = NEGEDGE ? ~clk : clk;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_ctrl  = out_valid ? r_m_ctrl : CTRL_IDLE;
    assign out_data  = out_valid ? r_m_data : '0;
    assign occupancy = r_state;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_m_ctrl_nxt = r_m_ctrl;
        w_m_data_nxt = r_m_data;
        w_s_ctrl_nxt = r_s_ctrl;
        w_s_data_nxt = r_s_data;
        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_m_ctrl_nxt = CTRL_IDLE;
            w_m_data_nxt = '0;
            w_s_ctrl_nxt = CTRL_IDLE;
            w_s_data_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_m_ctrl_nxt = in_ctrl;
                        w_m_data_nxt = in_data;
                        w_state_nxt  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_m_ctrl_nxt = in_ctrl;
                        w_m_data_nxt = in_data;
                    end else if (w_accept) begin
                        w_s_ctrl_nxt = in_ctrl;
                        w_s_data_nxt = in_data;
                        w_state_nxt  = ST_FULL;
                    end else if (w_pop) begin
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_m_ctrl_nxt = r_s_ctrl;
                        w_m_data_nxt = r_s_data;
                        w_state_nxt  = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_m_ctrl <= CTRL_IDLE;
            r_s_ctrl <= CTRL_IDLE;
        end else begin
            r_state  <= w_state_nxt;
            r_m_ctrl <= w_m_ctrl_nxt;
            r_s_ctrl <= w_s_ctrl_nxt;
        end
    end

    // Data needs no reset: it is masked to zero whenever out_valid is low.
    always_ff @(posedge w_clk) begin
        r_m_data <= w_m_data_nxt;
        r_s_data <= w_s_data_nxt;
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a falling-edge instance plus a rising-edge
// instance on the inverted clock, which must track it exactly.
module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       clk_n;
    logic       rst_n, flush, in_valid, out_ready;
    logic [1:0] in_ctrl;
    logic [7:0] in_data;

    logic       in_ready, out_valid;
    logic [1:0] out_ctrl, occupancy;
    logic [7:0] out_data;
    logic       in_ready_p, out_valid_p;
    logic [1:0] out_ctrl_p, occupancy_p;
    logic [7:0] out_data_p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign clk_n = ~clk;

    pipe_skid_reg #(.CTRL_W(2), .DATA_W(8), .CTRL_IDLE(2'b00), .NEGEDGE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
    );

    pipe_skid_reg #(.CTRL_W(2), .DATA_W(8), .CTRL_IDLE(2'b00), .NEGEDGE(1'b0)) u_pos (
        .clk(clk_n), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_p),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_p), .out_ready(out_ready),
        .out_ctrl(out_ctrl_p), .out_data(out_data_p), .occupancy(occupancy_p)
    );

    // Advance past the next falling (active) edge of u_dut.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = 2'b00; in_data = 8'h00;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (out_ctrl !== 2'b00) begin bad++; $display("FAIL rst_out_ctrl got=%b exp=00", out_ctrl); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        @(posedge clk); #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_ctrl = 2'(i);
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, 8'(i)); end
            total++; if (out_ctrl !== 2'(i)) begin bad++; $display("FAIL stream_ctrl[%0d] got=%b exp=%b", i, out_ctrl, 2'(i)); end
            total++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin bad++; $display("FAIL stream_flow[%0d] rdy=%b occ=%0d exp rdy=1 occ=1", i, in_ready, occupancy); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain vld=%b occ=%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b01; in_data = 8'h0A;
        step();
        total++; if (out_data !== 8'h0A || occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_a data=%h occ=%0d rdy=%b exp 0a/1/1", out_data, occupancy, in_ready); end
        in_data = 8'h0B;
        step();
        total++; if (out_data !== 8'h0A || occupancy !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_b data=%h occ=%0d rdy=%b exp 0a/2/0", out_data, occupancy, in_ready); end
        in_data = 8'h0C;
        step();
        step();
        total++; if (out_data !== 8'h0A || occupancy !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold data=%h occ=%0d rdy=%b exp 0a/2/0", out_data, occupancy, in_ready); end
        out_ready = 1'b1;
        step();
        total++; if (out_data !== 8'h0B || occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_pop_a data=%h occ=%0d rdy=%b exp 0b/1/1", out_data, occupancy, in_ready); end
        step();
        total++; if (out_data !== 8'h0C || occupancy !== 2'd1) begin bad++; $display("FAIL bp_pop_b data=%h occ=%0d exp 0c/1", out_data, occupancy); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL bp_pop_c vld=%b occ=%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL fl_fill occ=%0d exp=2", occupancy); end
        flush = 1'b1; in_data = 8'h33;
        step();
        total++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL fl_full vld=%b ctrl=%b occ=%0d rdy=%b exp 0/00/0/1", out_valid, out_ctrl, occupancy, in_ready); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL fl_no33 vld=%b data=%h exp 0/00", out_valid, out_data); end
        // Flush while ONE and accepting: the incoming beat is discarded too.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
        step();
        flush = 1'b1; in_data = 8'h55;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL fl_one vld=%b occ=%0d exp 0/0", out_valid, occupancy); end
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL fl_no55 vld=%b data=%h exp 0/00", out_valid, out_data); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_data = 8'h5A;
        step();
        total++; if (out_ctrl !== 2'b11 || out_data !== 8'h5A) begin bad++; $display("FAIL bub_load ctrl=%b data=%h exp 11/5a", out_ctrl, out_data); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || out_data !== 8'h00) begin bad++; $display("FAIL bub_mask vld=%b ctrl=%b data=%h exp 0/00/00", out_valid, out_ctrl, out_data); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b10; in_data = 8'h77;
        step();
        in_data = 8'h78;
        step();
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || out_data !== 8'h00) begin bad++; $display("FAIL rstf_out vld=%b ctrl=%b data=%h exp 0/00/00", out_valid, out_ctrl, out_data); end
        total++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin bad++; $display("FAIL rstf_flow rdy=%b occ=%0d exp 1/0", in_ready, occupancy); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL rstf_lost vld=%b occ=%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_edge_select();
        logic [13:0] snap;
        for (int i = 0; i < 24; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_ctrl   = 2'($urandom);
            if (in_ready) in_data = 8'($urandom);
            step();
            total++;
            if ({in_ready, out_valid, out_ctrl, out_data, occupancy} !== {in_ready_p, out_valid_p, out_ctrl_p, out_data_p, occupancy_p}) begin
                bad++;
                $display("FAIL edge_match[%0d] neg=%b/%b/%b/%h/%0d pos=%b/%b/%b/%h/%0d", i, in_ready, out_valid, out_ctrl, out_data, occupancy, in_ready_p, out_valid_p, out_ctrl_p, out_data_p, occupancy_p);
            end
            snap = {in_ready, out_valid, out_ctrl, out_data, occupancy};
            @(posedge clk); #1;
            total++;
            if ({in_ready, out_valid, out_ctrl, out_data, occupancy} !== snap) begin
                bad++;
                $display("FAIL edge_rise_stable[%0d] got=%h exp=%h", i, {in_ready, out_valid, out_ctrl, out_data, occupancy}, snap);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_reset_full();
        test_edge_select();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
